// File: rtl/inst_fetch_if.sv
// Fetch-control bundle between the decode/ALU side and the program-counter
// stage. The slave side (inst_fetch) samples every control on the rising
// clock edge and presents registered outputs.
//
// Control contract (no valid/ready pair on this bundle): each control input
// counts as a request only when sampled high on a rising edge. It is always
// accepted in the state where it is meaningful and silently ignored
// elsewhere. Outputs change only on edges or on asynchronous reset.
interface inst_fetch_if #(
  parameter int A    = 16,
  parameter int OFFW = 8,
  parameter int CNTW = 16
);

  logic            Start;
  logic            Halt;
  logic            Stall;
  logic            JumpEn;
  logic [A-1:0]    JumpTarget;
  logic            BranchEn;
  logic [OFFW-1:0] BranchOffset;
  logic [A-1:0]    ProgCtr;
  logic            Running;
  logic            Done;
  logic [CNTW-1:0] CycleCnt;

  // Control source: decode / ALU flag logic / test driver
  modport master (
    output Start, Halt, Stall, JumpEn, JumpTarget, BranchEn, BranchOffset,
    input  ProgCtr, Running, Done, CycleCnt
  );

  // Program-counter stage
  modport slave (
    input  Start, Halt, Stall, JumpEn, JumpTarget, BranchEn, BranchOffset,
    output ProgCtr, Running, Done, CycleCnt
  );

endinterface

// File: rtl/inst_fetch.sv
// Program counter and fetch control for the instruction ROM.
// Sequences start, sequential advance, relative branch, absolute jump,
// stall and halt, and counts cycles spent running for benchmarking.
// The ROM is combinational, so the instruction for ProgCtr is valid in the
// same cycle that ProgCtr updates.
module inst_fetch #(
  parameter int A          = 16,
  parameter int OFFW       = 8,
  parameter int START_ADDR = 0,
  parameter int CNTW       = 16
) (
  input  logic       Clk,
  input  logic       Reset,      // asynchronous, active low
  inst_fetch_if.slave bus,
  output logic [1:0] fsm_state   // current FSM state for observation
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  localparam logic [A-1:0] START_PC = A'(START_ADDR);

  logic [1:0]      state_q, state_d;
  logic [A-1:0]    pc_q, pc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            running_q;
  logic            done_q;

  logic [A-1:0]    offset_ext;
  logic [A-1:0]    pc_branch;
  logic [A-1:0]    pc_inc;
  logic [CNTW-1:0] cnt_inc;

  // Sign-extend the offset and form the candidate next PCs (wrap is silent)
  always_comb begin
    offset_ext = {{(A-OFFW){bus.BranchOffset[OFFW-1]}}, bus.BranchOffset};
    pc_branch  = pc_q + offset_ext;
    pc_inc     = pc_q + A'(1);
    cnt_inc    = (cnt_q == {CNTW{1'b1}}) ? cnt_q : cnt_q + CNTW'(1);
  end

  // Next-state, next-PC and next-count selection with RUN priority ordering
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, HALTED: begin
        // Both idle-like states restart the same way; other controls ignored
        if (bus.Start) begin
          state_d = RUN;
          pc_d    = START_PC;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Every RUN edge counts, including stalls and the halting edge
        cnt_d = cnt_inc;
        if (bus.Halt) begin
          state_d = HALTED;           // PC stays on the halting instruction
        end else if (bus.Stall) begin
          pc_d = pc_q;
        end else if (bus.JumpEn) begin
          pc_d = bus.JumpTarget;      // jump beats a simultaneous branch
        end else if (bus.BranchEn) begin
          pc_d = pc_branch;
        end else begin
          pc_d = pc_inc;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, PC, counter and registered status decodes
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == HALTED);
    end
  end

  assign bus.ProgCtr  = pc_q;
  assign bus.Running  = running_q;
  assign bus.Done     = done_q;
  assign bus.CycleCnt = cnt_q;
  assign fsm_state    = state_q;

  // Status flags are exclusive decodes of the state
  a_status_exclusive: assert property (
    @(posedge Clk) disable iff (!Reset) !(running_q && done_q));

  // Status flags always agree with the state register
  a_status_matches_state: assert property (
    @(posedge Clk) disable iff (!Reset)
      (running_q == (state_q == RUN)) && (done_q == (state_q == HALTED)));

  // While halted without a restart, PC and count are frozen
  a_halted_holds: assert property (
    @(posedge Clk) disable iff (!Reset)
      (state_q == HALTED && !bus.Start) |=> ($stable(pc_q) && $stable(cnt_q)));

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a table of single-edge vectors with
// hand-computed expectations, plus sequences for async reset and counter
// saturation on a second instance built with a 4-bit counter.
module tb_inst_fetch;

  logic Clk;
  logic Reset;
  logic [1:0] fsm_state0;
  logic [1:0] fsm_state1;

  int n_cmp = 0;
  int n_bad = 0;

  inst_fetch_if #(.A(16), .OFFW(8), .CNTW(16)) bus0 ();
  inst_fetch_if #(.A(16), .OFFW(8), .CNTW(4))  bus1 ();

  inst_fetch #(.A(16), .OFFW(8), .START_ADDR(0), .CNTW(16)) dut0 (
    .Clk(Clk), .Reset(Reset), .bus(bus0), .fsm_state(fsm_state0));

  inst_fetch #(.A(16), .OFFW(8), .START_ADDR(0), .CNTW(4)) dut1 (
    .Clk(Clk), .Reset(Reset), .bus(bus1), .fsm_state(fsm_state1));

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic        start, halt, stall, jen, ben;
    logic [15:0] jt;
    logic [7:0]  off;
    logic [15:0] exp_pc;
    logic        exp_run, exp_done;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string name, input logic start, input logic halt,
                     input logic stall, input logic jen, input logic [15:0] jt,
                     input logic ben, input logic [7:0] off,
                     input logic [15:0] exp_pc, input logic exp_run,
                     input logic exp_done, input logic [15:0] exp_cnt);
    vec_t v;
    v.name = name; v.start = start; v.halt = halt; v.stall = stall;
    v.jen = jen; v.jt = jt; v.ben = ben; v.off = off;
    v.exp_pc = exp_pc; v.exp_run = exp_run; v.exp_done = exp_done;
    v.exp_cnt = exp_cnt;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Driver for the main instance
  task automatic drive0(input logic start, input logic halt, input logic stall,
                        input logic jen, input logic [15:0] jt,
                        input logic ben, input logic [7:0] off);
    bus0.Start = start; bus0.Halt = halt; bus0.Stall = stall;
    bus0.JumpEn = jen; bus0.JumpTarget = jt;
    bus0.BranchEn = ben; bus0.BranchOffset = off;
  endtask

  task automatic expect0(input string name, input logic [15:0] pc,
                         input logic run, input logic done,
                         input logic [15:0] cnt);
    logic [1:0] st;
    st = run ? 2'd1 : (done ? 2'd2 : 2'd0);
    check({name, ".pc"},    32'(bus0.ProgCtr),  32'(pc));
    check({name, ".run"},   32'(bus0.Running),  32'(run));
    check({name, ".done"},  32'(bus0.Done),     32'(done));
    check({name, ".cnt"},   32'(bus0.CycleCnt), 32'(cnt));
    check({name, ".state"}, 32'(fsm_state0),    32'(st));
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // Main-instance vector table: each row is applied for one edge
    //   name         st h  s  j  jt       b  off    pc       run done cnt
    add("idle_ign",   0, 1, 1, 1, 16'd99,  1, 8'h05, 16'd0,    0, 0, 16'd0);
    add("start",      1, 0, 0, 0, 16'd0,   0, 8'h00, 16'd0,    1, 0, 16'd0);
    add("seq1",       0, 0, 0, 0, 16'd0,   0, 8'h00, 16'd1,    1, 0, 16'd1);
    add("seq2",       0, 0, 0, 0, 16'd0,   0, 8'h00, 16'd2,    1, 0, 16'd2);
    add("seq3",       0, 0, 0, 0, 16'd0,   0, 8'h00, 16'd3,    1, 0, 16'd3);
    add("seq4",       0, 0, 0, 0, 16'd0,   0, 8'h00, 16'd4,    1, 0, 16'd4);
    add("seq5",       0, 0, 0, 0, 16'd0,   0, 8'h00, 16'd5,    1, 0, 16'd5);
    add("start_run",  1, 0, 0, 0, 16'd0,   0, 8'h00, 16'd6,    1, 0, 16'd6);
    add("jmp10",      0, 0, 0, 1, 16'd10,  0, 8'h00, 16'd10,   1, 0, 16'd7);
    add("br_m3",      0, 0, 0, 0, 16'd0,   1, 8'hFD, 16'd7,    1, 0, 16'd8);
    add("br_p5",      0, 0, 0, 0, 16'd0,   1, 8'h05, 16'd12,   1, 0, 16'd9);
    add("jmp_top",    0, 0, 0, 1, 16'hFFFF,0, 8'h00, 16'hFFFF, 1, 0, 16'd10);
    add("wrap_up",    0, 0, 0, 0, 16'd0,   0, 8'h00, 16'd0,    1, 0, 16'd11);
    add("wrap_down",  0, 0, 0, 0, 16'd0,   1, 8'hFF, 16'hFFFF, 1, 0, 16'd12);
    add("wrap_up2",   0, 0, 0, 0, 16'd0,   0, 8'h00, 16'd0,    1, 0, 16'd13);
    add("jmp20",      0, 0, 0, 1, 16'd20,  0, 8'h00, 16'd20,   1, 0, 16'd14);
    add("jmp_vs_br",  0, 0, 0, 1, 16'd300, 1, 8'h04, 16'd300,  1, 0, 16'd15);
    add("stall1",     0, 0, 1, 0, 16'd0,   0, 8'h00, 16'd300,  1, 0, 16'd16);
    add("stall2",     0, 0, 1, 0, 16'd0,   0, 8'h00, 16'd300,  1, 0, 16'd17);
    add("stall3",     0, 0, 1, 0, 16'd0,   0, 8'h00, 16'd300,  1, 0, 16'd18);
    add("stall_jmp",  0, 0, 1, 1, 16'd5,   1, 8'h02, 16'd300,  1, 0, 16'd19);
    add("br_max",     0, 0, 0, 0, 16'd0,   1, 8'h7F, 16'd427,  1, 0, 16'd20);
    add("br_min",     0, 0, 0, 0, 16'd0,   1, 8'h80, 16'd299,  1, 0, 16'd21);
    add("jmp40",      0, 0, 0, 1, 16'd40,  0, 8'h00, 16'd40,   1, 0, 16'd22);
    add("halt_jmp",   0, 1, 0, 1, 16'd99,  0, 8'h00, 16'd40,   0, 1, 16'd23);
    add("hlt_jmp",    0, 0, 0, 1, 16'd7,   0, 8'h00, 16'd40,   0, 1, 16'd23);
    add("hlt_br",     0, 0, 0, 0, 16'd0,   1, 8'h03, 16'd40,   0, 1, 16'd23);
    add("hlt_stall",  0, 1, 1, 0, 16'd0,   0, 8'h00, 16'd40,   0, 1, 16'd23);
    add("restart",    1, 0, 0, 0, 16'd0,   0, 8'h00, 16'd0,    1, 0, 16'd0);
    add("rs_seq1",    0, 0, 0, 0, 16'd0,   0, 8'h00, 16'd1,    1, 0, 16'd1);
    add("rs_seq2",    0, 0, 0, 0, 16'd0,   0, 8'h00, 16'd2,    1, 0, 16'd2);
    add("jmp77",      0, 0, 0, 1, 16'd77,  0, 8'h00, 16'd77,   1, 0, 16'd3);

    // Reset with all inputs quiet
    Reset = 1'b0;
    drive0(0, 0, 0, 0, 16'd0, 0, 8'h00);
    bus1.Start = 0; bus1.Halt = 0; bus1.Stall = 0; bus1.JumpEn = 0;
    bus1.JumpTarget = '0; bus1.BranchEn = 0; bus1.BranchOffset = '0;
    #23;
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    expect0("reset", 16'd0, 0, 0, 16'd0);

    // Table sweep
    foreach (vq[i]) begin
      drive0(vq[i].start, vq[i].halt, vq[i].stall, vq[i].jen, vq[i].jt,
             vq[i].ben, vq[i].off);
      tick();
      expect0(vq[i].name, vq[i].exp_pc, vq[i].exp_run, vq[i].exp_done,
              vq[i].exp_cnt);
    end

    // Asynchronous reset mid-cycle at PC=77 clears outputs before any edge
    drive0(0, 0, 0, 0, 16'd0, 0, 8'h00);
    #2;
    Reset = 1'b0;
    #1;
    expect0("async_rst", 16'd0, 0, 0, 16'd0);
    @(negedge Clk);
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect0("post_rst_idle", 16'd0, 0, 0, 16'd0);
    end
    drive0(1, 0, 0, 0, 16'd0, 0, 8'h00);
    tick();
    expect0("post_rst_start", 16'd0, 1, 0, 16'd0);
    drive0(0, 0, 0, 0, 16'd0, 0, 8'h00);
    tick();
    expect0("post_rst_seq", 16'd1, 1, 0, 16'd1);

    // 4-bit counter instance: saturation and Start ignored while running
    check("c4_reset_pc",  32'(bus1.ProgCtr),  32'd0);
    check("c4_reset_cnt", 32'(bus1.CycleCnt), 32'd0);
    bus1.Start = 1;
    tick();
    check("c4_start_run", 32'(bus1.Running), 32'd1);
    check("c4_start_cnt", 32'(bus1.CycleCnt), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      bus1.Start = (k >= 8 && k <= 10) ? 1'b1 : 1'b0;
      tick();
      check($sformatf("c4_pc%0d", k),  32'(bus1.ProgCtr),  32'(k));
      check($sformatf("c4_cnt%0d", k), 32'(bus1.CycleCnt), (k > 15) ? 32'd15 : 32'(k));
    end
    check("c4_state", 32'(fsm_state1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
